spi_master_ctl: RTL

//  SPI master (initiator) that drives the CPLD spi_ctl slave from a host-side parallel request port.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_clk_div.sv | 35 +++
 rtl/spi_master_ctl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, frame layout
// constants and a helper that assembles the 16-bit outgoing frame.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int          FRAME_BITS = 16;
  localparam int          RW_BIT     = 15;
  localparam logic [7:0]  DUMMY_BYTE = 8'h00;
  localparam logic        CPOL       = 1'b0;
  // Index of the last sck half-period in a frame (32 halves, 0..31).
  localparam logic [4:0]  LAST_HALF  = 5'd31;

  // Byte 0 = {rw, addr}; byte 1 = write data, or the dummy byte on a read.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       rw,
                                                        input logic [6:0] addr,
                                                        input logic [7:0] wdata);
    return {rw, addr, (rw ? DUMMY_BYTE : wdata)};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master.
//  clk      in   system clock
//  reset_n  in   asynchronous active-low reset
//  clear_i  in   holds the counter at zero (asserted while the master is idle,
//                so the first half-period of every frame is full length)
//  tick_o   out  one-cycle pulse on the last clk cycle of each half-period
module spi_clk_div #(
  parameter int CLK_DIV = 4  // clk cycles per sck half-period, >= 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int              CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == LAST)) cnt_d = '0;
  end

  assign tick_o = !clear_i && (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_ctl.sv
// SPI mode-0 master: turns one host request into a 16-bit frame
// ({rw, addr} then wdata or a dummy byte), MSB first.
//  clk, reset_n          system clock, asynchronous active-low reset
//  start, rw, addr, wdata request strobe and fields (captured in IDLE)
//  busy, done, rdata     frame in progress, completion pulse, last 8 miso bits
//  nss, sck, mosi, miso  SPI pins (nss active low, sck idles low)
module spi_master_ctl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4  // clk cycles per sck half-period, >= 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       nss,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  state_e      state_q, state_d;
  // Holds the bits still to be sent; the bit currently on mosi is not kept.
  logic [14:0] shift_tx_q, shift_tx_d;
  logic [7:0]  shift_rx_q, shift_rx_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        nss_q, nss_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;

  logic [FRAME_BITS-1:0] frame;
  logic                  tick;

  assign frame = build_frame(rw, addr, wdata);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (state_q == IDLE),
    .tick_o  (tick)
  );

  always_comb begin
    // NOTE: every next-state signal is defaulted first so no branch can leave
    // a signal unassigned and infer a latch.
    state_d    = state_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    bit_cnt_d  = bit_cnt_q;
    nss_d      = nss_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rdata_d    = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_tx_d = frame[RW_BIT-1:0];
          mosi_d     = frame[RW_BIT];
          nss_d      = 1'b0;
          sck_d      = CPOL;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        // End of the setup half: first rising edge, first miso sample.
        if (tick) begin
          sck_d      = ~CPOL;
          shift_rx_d = {shift_rx_q[6:0], miso};
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // Even halves are sck-high (end in a falling edge), odd halves are
        // sck-low (end in a rising edge); the final low half ends the frame.
        if (tick) begin
          if (bit_cnt_q == LAST_HALF) begin
            bit_cnt_d = '0;
            state_d   = HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (!bit_cnt_q[0]) begin
              sck_d      = CPOL;
              mosi_d     = (bit_cnt_q == LAST_HALF - 5'd1) ? 1'b0 : shift_tx_q[14];
              shift_tx_d = {shift_tx_q[13:0], 1'b0};
            end else begin
              sck_d      = ~CPOL;
              shift_rx_d = {shift_rx_q[6:0], miso};
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          nss_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rdata_d = shift_rx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      bit_cnt_q  <= '0;
      nss_q      <= 1'b1;
      sck_q      <= CPOL;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      bit_cnt_q  <= bit_cnt_d;
      nss_q      <= nss_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign nss   = nss_q;
  assign sck   = sck_q;
  assign mosi  = mosi_q;

endmodule
